// File: rtl/conv_idx_pkg.sv
// Shared widths and FSM encoding for the convolution index encoder slice.
package conv_idx_pkg;

  localparam int unsigned KERNEL_MAX = 3;
  localparam int unsigned OUT_EDGE   = 2;

  localparam int unsigned IDX_W   = $clog2(OUT_EDGE * OUT_EDGE * KERNEL_MAX * KERNEL_MAX);
  localparam int unsigned PIX_W   = $clog2(OUT_EDGE * OUT_EDGE);
  localparam int unsigned TAP_W   = $clog2(KERNEL_MAX * KERNEL_MAX);
  localparam int unsigned COORD_W = $clog2(OUT_EDGE * KERNEL_MAX);
  localparam int unsigned STR_W   = $clog2(KERNEL_MAX);

  typedef enum logic [1:0] {IDLE, CALC, EMIT, EMPTY} state_e;

endpackage

// File: rtl/idx_cover_check.sv
// Per-pixel test: does output pixel Pix read input (x, y) through some kernel tap,
// and if so, which tap.
module idx_cover_check #(
  parameter int unsigned K   = 3,
  parameter int unsigned N   = 2,
  parameter int unsigned Pix = 0
) (
  input  logic [$clog2(N*K)-1:0] x,
  input  logic [$clog2(N*K)-1:0] y,
  input  logic [$clog2(K)-1:0]   stride,
  input  logic [$clog2(K)-1:0]   kernel_width,
  output logic                   hit,
  output logic [$clog2(K*K)-1:0] tap
);

  localparam int unsigned CoordW = $clog2(N * K);
  localparam int unsigned SW     = CoordW + 2;
  localparam int unsigned TapW   = $clog2(K * K);

  localparam logic [SW-1:0] Row = SW'(Pix / N);
  localparam logic [SW-1:0] Col = SW'(Pix % N);

  logic signed [SW-1:0] kx, ky, kw;

  assign kw = $signed(SW'(kernel_width));
  assign kx = $signed(SW'(x)) - $signed(SW'(stride) * Row);
  assign ky = $signed(SW'(y)) - $signed(SW'(stride) * Col);

  assign hit = !kx[SW-1] && (kx < kw) && !ky[SW-1] && (ky < kw);

  // Only meaningful when hit is set.
  assign tap = TapW'(kx) * TapW'(kernel_width) + TapW'(ky);

endmodule

// File: rtl/index_encoder.sv
// Scatter-side index encoder: lists every (pixel, kernel tap) pair that reads a given
// input index, one pair per beat, ascending pixel order.
module index_encoder
  import conv_idx_pkg::*;
#(
  parameter int unsigned K = KERNEL_MAX,
  parameter int unsigned N = OUT_EDGE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(N*N*K*K)-1:0] req_index,
  input  logic [$clog2(K)-1:0]       stride,
  input  logic [$clog2(K)-1:0]       kernel_width,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N*N)-1:0]     out_pixel_number,
  output logic [$clog2(K*K)-1:0]     out_current_index,
  output logic                       out_last,
  output logic                       out_none
);

  localparam int unsigned NumPix = N * N;
  localparam int unsigned Edge   = N * K;
  localparam int unsigned IdxW   = $clog2(N * N * K * K);
  localparam int unsigned CoordW = $clog2(N * K);
  localparam int unsigned StrW   = $clog2(K);
  localparam int unsigned PixW   = $clog2(N * N);
  localparam int unsigned TapW   = $clog2(K * K);

  state_e state_q, state_d;
  logic [CoordW-1:0] x_q, x_d, y_q, y_d;
  logic [StrW-1:0]   stride_q, stride_d, kw_q, kw_d;
  logic [NumPix-1:0] mask_q, mask_d;

  logic [NumPix-1:0] hits;
  logic [TapW-1:0]   taps [NumPix];
  logic [PixW-1:0]   pix;
  logic              one_left;

  for (genvar p = 0; p < NumPix; p++) begin : g_pix
    idx_cover_check #(
      .K   (K),
      .N   (N),
      .Pix (p)
    ) u_check (
      .x            (x_q),
      .y            (y_q),
      .stride       (stride_q),
      .kernel_width (kw_q),
      .hit          (hits[p]),
      .tap          (taps[p])
    );
  end

  // Lowest set mask bit wins, giving ascending pixel order.
  always_comb begin
    pix = '0;
    for (int i = NumPix - 1; i >= 0; i--) begin
      if (mask_q[i]) pix = PixW'(i);
    end
  end

  assign one_left = (mask_q & (mask_q - NumPix'(1))) == '0;

  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    y_d               = y_q;
    stride_d          = stride_q;
    kw_d              = kw_q;
    mask_d            = mask_q;
    req_ready         = 1'b0;
    out_valid         = 1'b0;
    out_pixel_number  = '0;
    out_current_index = '0;
    out_last          = 1'b0;
    out_none          = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          x_d      = CoordW'(req_index / IdxW'(Edge));
          y_d      = CoordW'(req_index % IdxW'(Edge));
          stride_d = stride;
          kw_d     = kernel_width;
          state_d  = CALC;
        end
      end
      CALC: begin
        mask_d  = hits;
        state_d = (|hits) ? EMIT : EMPTY;
      end
      EMIT: begin
        out_valid         = 1'b1;
        out_pixel_number  = pix;
        out_current_index = taps[pix];
        out_last          = one_left;
        if (out_ready) begin
          mask_d[pix] = 1'b0;
          if (one_left) state_d = IDLE;
        end
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_none  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      stride_q <= '0;
      kw_q     <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      stride_q <= stride_d;
      kw_q     <= kw_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: tb/tb_index_encoder.sv
// Scoreboard bench for index_encoder: expected bursts come from brute-force inversion
// of the kernel-to-input decoder.
module tb_index_encoder;
  import conv_idx_pkg::*;

  localparam int K = KERNEL_MAX;
  localparam int N = OUT_EDGE;
  localparam int E = N * K;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_index;
  logic [STR_W-1:0]   stride;
  logic [STR_W-1:0]   kernel_width;
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pixel_number;
  logic [TAP_W-1:0]   out_current_index;
  logic               out_last;
  logic               out_none;

  index_encoder #(
    .K (K),
    .N (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_index         (req_index),
    .stride            (stride),
    .kernel_width      (kernel_width),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pixel_number  (out_pixel_number),
    .out_current_index (out_current_index),
    .out_last          (out_last),
    .out_none          (out_none)
  );

  typedef struct {
    int pix;
    int tap;
    bit last;
    bit none;
    int idx;
    int s;
    int kw;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  bit    rand_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward decoder: input index read by (tap, pixel).
  function automatic int decode(int tap, int pix, int s, int kw);
    if (kw == 0) return -1;
    return (s * (pix / N) + tap / kw) * E + (s * (pix % N) + tap % kw);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(int idx, int s, int kw);
    beat_t tmp[$];
    beat_t b;
    for (int p = 0; p < N * N; p++) begin
      for (int t = 0; t < kw * kw; t++) begin
        if (decode(t, p, s, kw) == idx) begin
          b.pix = p; b.tap = t; b.last = 0; b.none = 0;
          b.idx = idx; b.s = s; b.kw = kw;
          tmp.push_back(b);
        end
      end
    end
    if (tmp.size() == 0) begin
      b.pix = 0; b.tap = 0; b.last = 1; b.none = 1;
      b.idx = idx; b.s = s; b.kw = kw;
      tmp.push_back(b);
    end else begin
      tmp[tmp.size()-1].last = 1;
    end
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
  endtask

  // Monitor: pops on every accepted beat and checks hold-stability under backpressure.
  bit         stall_prev = 0;
  logic [7:0] held;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_outputs", int'({out_pixel_number, out_current_index, out_last, out_none}),
              int'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_beat: got pixel %0d tap %0d, expected no beat",
                   out_pixel_number, out_current_index);
        end else begin
          b = exp_q.pop_front();
          check("pixel_number", int'(out_pixel_number), b.pix);
          check("current_index", int'(out_current_index), b.tap);
          check("last", int'(out_last), int'(b.last));
          check("none", int'(out_none), int'(b.none));
          if (!b.none)
            check("round_trip", decode(int'(out_current_index), int'(out_pixel_number), b.s,
                  b.kw), b.idx);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = 8'({out_pixel_number, out_current_index, out_last, out_none});
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Returns at #1 into the cycle after acceptance.
  task automatic send(int idx, int s, int kw);
    int n = 0;
    @(posedge clk) #1;
    req_valid    = 1'b1;
    req_index    = IDX_W'(idx);
    stride       = STR_W'(s);
    kernel_width = STR_W'(kw);
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 300);
    if (!req_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL req_timeout: req_ready still 0 after %0d cycles, expected 1", n);
    end else begin
      push_expected(idx, s, kw);
    end
    @(posedge clk) #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_index    = '0;
    stride       = '0;
    kernel_width = '0;
    out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", int'(req_ready), 0);
    check("valid_in_reset", int'(out_valid), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", int'(req_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_out_none", int'(out_none), 0);
    check("reset_pixel", int'(out_pixel_number), 0);
    check("reset_tap", int'(out_current_index), 0);

    // Four-beat burst with latency and throughput checks.
    send(7, 1, 3);
    @(negedge clk);
    check("calc_cycle_valid", int'(out_valid), 0);
    check("calc_cycle_ready", int'(req_ready), 0);
    @(negedge clk);
    check("first_beat_at_t2", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("beat_per_cycle", int'(out_valid), 1);
      check("busy_ready", int'(req_ready), 0);
    end
    @(negedge clk);
    check("ready_after_last", int'(req_ready), 1);
    check("idle_valid", int'(out_valid), 0);
    drain();

    send(0, 1, 3);
    drain();
    send(35, 1, 3);
    drain();
    send(21, 3, 3);
    drain();

    // Backpressure on beat 2.
    send(7, 1, 3);
    @(posedge clk) #1;
    @(posedge clk) #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pixel", int'(out_pixel_number), 1);
      check("stall_req_ready", int'(req_ready), 0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    drain();

    // Reset during beat 2 drops the burst.
    send(7, 1, 3);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", int'(out_valid), 0);
    check("post_rst_ready", int'(req_ready), 1);
    send(0, 1, 3);
    drain();

    // Random requests under random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, E * E - 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) drain();
    end
    rand_ready = 0;
    @(posedge clk) #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/index_encoder.md
Name: index_encoder

Overview:
- Inverse of the kernel-to-input index decoder. Given one flattened input-image index in the (N*K)x(N*K) input grid, it lists every (pixel_number, current_index) pair whose decoded_index equals that input index, one pair per beat.
- Sits on the scatter side of the convolution datapath: it routes one incoming input word to every output-pixel/kernel-tap slot that consumes it.
- Request and output each use a valid/ready handshake. Every request produces a burst of one or more beats terminated by out_last.

Parameters:
- K, 3, maximum kernel edge; kernel tap index range 0..K*K-1.
- N, 2, output edge; pixel_number range 0..N*N-1; input grid is (N*K)x(N*K).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_index  input  $clog2(N*N*K*K)  flattened input index, row-major, row length N*K.
- stride  input  $clog2(K)  window step; latched on request accept.
- kernel_width  input  $clog2(K)  active kernel edge; latched on request accept.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the beat.
- out_pixel_number  output  $clog2(N*N)  output pixel that uses the input index.
- out_current_index  output  $clog2(K*K)  kernel tap, equal to kx*kernel_width+ky.
- out_last  output  1  final beat of the burst.
- out_none  output  1  no pair covers the index; only valid on an out_last beat.

Behaviour:
- Reset values: req_ready=0 during reset and 1 in the first cycle after. out_valid, out_last and out_none are 0. The other outputs are 0. State is IDLE and the mask is cleared.
- States: IDLE, CALC, EMIT, EMPTY.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch x=req_index/(N*K), y=req_index%(N*K), stride and kernel_width, then go to CALC.
- CALC (one cycle):
  - For each p in 0..N*N-1: kx=x-stride*(p/N), ky=y-stride*(p%N).
  - Use signed arithmetic, width $clog2(N*K)+2.
  - mask[p]=1 when 0<=kx<kernel_width and 0<=ky<kernel_width.
  - Register the mask. If the mask is nonzero go to EMIT, else go to EMPTY.
- EMIT:
  - p = lowest set mask bit.
  - Drive out_valid=1, out_pixel_number=p, out_current_index=kx(p)*kernel_width+ky(p).
  - out_last=1 when exactly one mask bit remains.
  - On out_ready, clear mask[p]. If this was the last beat, go to IDLE.
- EMPTY: out_valid=1, out_last=1, out_none=1, other outputs 0. On out_ready, go to IDLE.
- Ordering and latency:
  - Beats come out in ascending pixel_number.
  - Request accepted in cycle T gives the first out_valid in cycle T+2.
  - One beat per cycle while out_ready stays high.
  - req_ready is low from T+1 until the cycle after the last beat is accepted.
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- kernel_width=0 always gives the EMPTY response.
- stride=0 is legal: all pixels with x<kernel_width and y<kernel_width hit.
- req_index >= (N*K)^2 is out of contract and its response is undefined.
- rst asserted in any state forces IDLE on the next edge, with out_valid=0 and the mask cleared. A burst interrupted by reset is dropped.
- Round-trip invariant: for every non-none beat, decoder(out_current_index, out_pixel_number, stride, kernel_width) = req_index.

Decomposition:
- Shared package conv_idx_pkg holds:
  - width localparams: IDX_W=$clog2(N*N*K*K), PIX_W=$clog2(N*N), TAP_W=$clog2(K*K), COORD_W=$clog2(N*K);
  - the state enum {IDLE, CALC, EMIT, EMPTY}.
- One sub-module, idx_cover_check: combinational per-pixel kx/ky computation and range test. It is instantiated N*N times by generate to build the mask.
- The priority pick and popcount-equals-one check stay in the top module.

Test Plan (K=3, N=2, 6x6 grid):
- req_index=7 (x1,y1), stride=1, kernel_width=3, out_ready=1 → beats (0,4), (1,3), (2,1), (3,0, last). First beat at T+2, then one beat per cycle.
- req_index=0, stride=1, kernel_width=3 → single beat (0,0) with out_last=1, out_none=0.
- req_index=35, stride=1, kernel_width=3 → single beat with out_none=1, out_last=1, pixel and tap 0.
- req_index=21 (x3,y3), stride=3, kernel_width=3 → single beat (3,0, last). Check the decoder round trip.
- Same stimulus as the first scenario, with out_ready held low 3 cycles on beat 2 → (1,3) stays stable; order and count are unchanged; req_ready stays 0 until after the last beat.
- rst pulsed during beat 2 of the first scenario → next cycle out_valid=0 and req_ready=1. A new request for req_index=0 then gives the correct single beat.
